// File: rtl/int_trap_ctrl_pkg.sv
// Shared definitions for the interrupt trap controller: FSM states and
// the RISC-V mcause constants.
package int_trap_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        HANDLER = 2'd2
    } trap_state_e;

    localparam int MCAUSE_INT_BIT = 31;
    localparam int CODE_MSI       = 3;
    localparam int CODE_MTI       = 7;
    localparam int CODE_MEI       = 11;

    localparam int DEFAULT_CUSTOM_CODE_BASE = 16;
    localparam int DEFAULT_CODE_W           = 27;

endpackage

// File: rtl/int_trap_ctrl_if.sv
// Interrupt sources, CSR enables and the trap handshake between the
// interrupt controller / CLINT / core and the trap controller.
interface int_trap_ctrl_if #(
    parameter int CODE_W = 27
);
    logic              mextern_int;
    logic [CODE_W-1:0] custom_int_code;
    logic              mtimer_int;
    logic              msoft_int;
    logic              csr_mstatus_mie;
    logic              csr_meie;
    logic              csr_mtie;
    logic              csr_msie;
    logic              trap_ack;
    logic              mret;
    logic              trap_req;
    logic [31:0]       trap_cause;
    logic              trap_taken;
    logic              in_handler;

    // The surrounding system drives sources, enables and the core handshake.
    modport master (
        output mextern_int, custom_int_code, mtimer_int, msoft_int,
               csr_mstatus_mie, csr_meie, csr_mtie, csr_msie,
               trap_ack, mret,
        input  trap_req, trap_cause, trap_taken, in_handler
    );

    modport slave (
        input  mextern_int, custom_int_code, mtimer_int, msoft_int,
               csr_mstatus_mie, csr_meie, csr_mtie, csr_msie,
               trap_ack, mret,
        output trap_req, trap_cause, trap_taken, in_handler
    );

endinterface

// File: rtl/int_cause_encoder.sv
// Combinational eligibility, e > s > t priority and mcause encoding
// of the currently winning interrupt source.
module int_cause_encoder
    import int_trap_ctrl_pkg::*;
#(
    parameter int CUSTOM_CODE_BASE = DEFAULT_CUSTOM_CODE_BASE,
    parameter int CODE_W           = DEFAULT_CODE_W
) (
    input  logic              mextern_int,
    input  logic [CODE_W-1:0] custom_int_code,
    input  logic              mtimer_int,
    input  logic              msoft_int,
    input  logic              csr_mstatus_mie,
    input  logic              csr_meie,
    input  logic              csr_mtie,
    input  logic              csr_msie,
    output logic              any,
    output logic [31:0]       cause
);

    logic        e;
    logic        s;
    logic        t;
    logic [30:0] custom_code;

    assign e   = csr_mstatus_mie & csr_meie & mextern_int;
    assign s   = csr_mstatus_mie & csr_msie & msoft_int;
    assign t   = csr_mstatus_mie & csr_mtie & mtimer_int;
    assign any = e | s | t;

    // Custom id k lands at CUSTOM_CODE_BASE + k - 1; legal ids never wrap.
    assign custom_code = 31'(CUSTOM_CODE_BASE) + 31'(custom_int_code) - 31'd1;

    always_comb begin
        cause = '0;
        if (e) begin
            cause[MCAUSE_INT_BIT] = 1'b1;
            cause[30:0] = (custom_int_code != '0) ? custom_code : 31'(CODE_MEI);
        end else if (s) begin
            cause[MCAUSE_INT_BIT] = 1'b1;
            cause[30:0] = 31'(CODE_MSI);
        end else if (t) begin
            cause[MCAUSE_INT_BIT] = 1'b1;
            cause[30:0] = 31'(CODE_MTI);
        end
    end

endmodule

// File: rtl/int_trap_ctrl.sv
// Trap request FSM: raises an interrupt trap to the core, freezes mcause
// until acceptance and masks further traps until mret.
module int_trap_ctrl
    import int_trap_ctrl_pkg::*;
#(
    parameter int CUSTOM_CODE_BASE = DEFAULT_CUSTOM_CODE_BASE,
    parameter int CODE_W           = DEFAULT_CODE_W
) (
    input  logic            hb_clk,
    input  logic            rst_n,
    int_trap_ctrl_if.slave  bus
);

    trap_state_e state;
    logic        any;
    logic [31:0] cause;

    int_cause_encoder #(
        .CUSTOM_CODE_BASE (CUSTOM_CODE_BASE),
        .CODE_W           (CODE_W)
    ) u_cause_encoder (
        .mextern_int     (bus.mextern_int),
        .custom_int_code (bus.custom_int_code),
        .mtimer_int      (bus.mtimer_int),
        .msoft_int       (bus.msoft_int),
        .csr_mstatus_mie (bus.csr_mstatus_mie),
        .csr_meie        (bus.csr_meie),
        .csr_mtie        (bus.csr_mtie),
        .csr_msie        (bus.csr_msie),
        .any             (any),
        .cause           (cause)
    );

    // The cause is only loaded on IDLE->REQ, so it stays frozen for the whole handshake.
    always_ff @(posedge hb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bus.trap_req   <= 1'b0;
            bus.trap_cause <= '0;
            bus.trap_taken <= 1'b0;
            bus.in_handler <= 1'b0;
        end else begin
            bus.trap_taken <= 1'b0;
            case (state)
                IDLE: begin
                    if (any) begin
                        state          <= REQ;
                        bus.trap_req   <= 1'b1;
                        bus.trap_cause <= cause;
                    end
                end
                REQ: begin
                    // Acceptance beats a global-disable withdraw in the same cycle.
                    if (bus.trap_ack) begin
                        state          <= HANDLER;
                        bus.trap_req   <= 1'b0;
                        bus.trap_taken <= 1'b1;
                        bus.in_handler <= 1'b1;
                    end else if (!bus.csr_mstatus_mie) begin
                        state        <= IDLE;
                        bus.trap_req <= 1'b0;
                    end
                end
                HANDLER: begin
                    if (bus.mret) begin
                        state          <= IDLE;
                        bus.in_handler <= 1'b0;
                    end
                end
                default: begin
                    state          <= IDLE;
                    bus.trap_req   <= 1'b0;
                    bus.in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_trap_ctrl.sv
// Directed, table-driven bench for int_trap_ctrl plus hand-written
// asynchronous reset sequences.
module tb_int_trap_ctrl;

    typedef struct {
        string       name;
        logic        mext;
        logic [26:0] code;
        logic        msoft;
        logic        mtim;
        logic        mie;
        logic        meie;
        logic        msie;
        logic        mtie;
        logic        ack;
        logic        mret;
        logic        exp_req;
        logic [31:0] exp_cause;
        logic        exp_taken;
        logic        exp_inh;
    } vec_t;

    logic hb_clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vecs[$];

    int_trap_ctrl_if #(.CODE_W(27)) bus ();

    int_trap_ctrl #(
        .CUSTOM_CODE_BASE (16),
        .CODE_W           (27)
    ) dut (
        .hb_clk (hb_clk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial hb_clk = 1'b0;
    always #5 hb_clk = ~hb_clk;

    task automatic addVec(input string name,
                          input logic mext, input logic [26:0] code,
                          input logic msoft, input logic mtim,
                          input logic mie, input logic meie,
                          input logic msie, input logic mtie,
                          input logic ack, input logic mret,
                          input logic req, input logic [31:0] cause,
                          input logic taken, input logic inh);
        vec_t v;
        v.name = name;   v.mext = mext;   v.code = code;
        v.msoft = msoft; v.mtim = mtim;   v.mie = mie;
        v.meie = meie;   v.msie = msie;   v.mtie = mtie;
        v.ack = ack;     v.mret = mret;
        v.exp_req = req; v.exp_cause = cause;
        v.exp_taken = taken; v.exp_inh = inh;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.mextern_int     = v.mext;
        bus.custom_int_code = v.code;
        bus.msoft_int       = v.msoft;
        bus.mtimer_int      = v.mtim;
        bus.csr_mstatus_mie = v.mie;
        bus.csr_meie        = v.meie;
        bus.csr_msie        = v.msie;
        bus.csr_mtie        = v.mtie;
        bus.trap_ack        = v.ack;
        bus.mret            = v.mret;
    endtask

    task automatic checkOutput(input string name, input logic req,
                               input logic [31:0] cause, input logic taken,
                               input logic inh);
        total++;
        if (bus.trap_req !== req) begin
            bad++;
            $display("[TB] FAIL %s trap_req: got %b expected %b", name, bus.trap_req, req);
        end
        total++;
        if (bus.trap_cause !== cause) begin
            bad++;
            $display("[TB] FAIL %s trap_cause: got %h expected %h", name, bus.trap_cause, cause);
        end
        total++;
        if (bus.trap_taken !== taken) begin
            bad++;
            $display("[TB] FAIL %s trap_taken: got %b expected %b", name, bus.trap_taken, taken);
        end
        total++;
        if (bus.in_handler !== inh) begin
            bad++;
            $display("[TB] FAIL %s in_handler: got %b expected %b", name, bus.in_handler, inh);
        end
    endtask

    task automatic quietInputs();
        bus.mextern_int     = 1'b0;
        bus.custom_int_code = '0;
        bus.msoft_int       = 1'b0;
        bus.mtimer_int      = 1'b0;
        bus.csr_mstatus_mie = 1'b1;
        bus.csr_meie        = 1'b1;
        bus.csr_msie        = 1'b1;
        bus.csr_mtie        = 1'b1;
        bus.trap_ack        = 1'b0;
        bus.mret            = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //     name                 mext code msft mtim mie meie msie mtie ack mret  req cause          tkn inh
        addVec("idle_quiet",        0,   0,   0,   0,   1,  1,   1,   1,   0,  0,    0,  32'h00000000,  0,  0);
        addVec("mei_custom5",       1,   5,   0,   0,   1,  1,   1,   1,   0,  0,    1,  32'h80000014,  0,  0);
        addVec("req_sticky",        0,   0,   0,   0,   1,  1,   1,   1,   0,  0,    1,  32'h80000014,  0,  0);
        addVec("ack_custom",        0,   0,   0,   0,   1,  1,   1,   1,   1,  0,    0,  32'h80000014,  1,  1);
        addVec("handler_hold",      0,   0,   0,   0,   1,  1,   1,   1,   0,  0,    0,  32'h80000014,  0,  1);
        addVec("mret_custom",       0,   0,   0,   0,   1,  1,   1,   1,   0,  1,    0,  32'h80000014,  0,  0);
        addVec("idle_again",        0,   0,   0,   0,   1,  1,   1,   1,   0,  0,    0,  32'h80000014,  0,  0);
        addVec("prio_all_mei",      1,   0,   1,   1,   1,  1,   1,   1,   0,  0,    1,  32'h8000000B,  0,  0);
        addVec("ack_prio",          1,   0,   1,   1,   1,  1,   1,   1,   1,  0,    0,  32'h8000000B,  1,  1);
        addVec("mret_prio",         0,   0,   0,   0,   1,  1,   1,   1,   0,  1,    0,  32'h8000000B,  0,  0);
        addVec("prio_meie_off",     1,   0,   1,   1,   1,  0,   1,   1,   0,  0,    1,  32'h80000003,  0,  0);
        addVec("withdraw",          0,   0,   0,   0,   0,  1,   1,   1,   0,  0,    0,  32'h80000003,  0,  0);
        addVec("withdrawn_idle",    0,   0,   0,   0,   0,  1,   1,   1,   0,  0,    0,  32'h80000003,  0,  0);
        addVec("mti_req",           0,   0,   0,   1,   1,  1,   1,   1,   0,  0,    1,  32'h80000007,  0,  0);
        addVec("frozen_cause",      1,   0,   0,   0,   1,  1,   1,   1,   0,  0,    1,  32'h80000007,  0,  0);
        addVec("ack_beats_withdraw",1,   0,   0,   0,   0,  1,   1,   1,   1,  0,    0,  32'h80000007,  1,  1);
        addVec("handler_mask",      0,   0,   1,   0,   1,  1,   1,   1,   0,  0,    0,  32'h80000007,  0,  1);
        addVec("ack_in_handler",    0,   0,   1,   0,   1,  1,   1,   1,   1,  0,    0,  32'h80000007,  0,  1);
        addVec("mret_msi_held",     0,   0,   1,   0,   1,  1,   1,   1,   0,  1,    0,  32'h80000007,  0,  0);
        addVec("msi_gap_two",       0,   0,   1,   0,   1,  1,   1,   1,   0,  0,    1,  32'h80000003,  0,  0);
        addVec("mret_in_req",       0,   0,   0,   0,   1,  1,   1,   1,   0,  1,    1,  32'h80000003,  0,  0);
        addVec("ack_msi",           0,   0,   0,   0,   1,  1,   1,   1,   1,  0,    0,  32'h80000003,  1,  1);
        addVec("taken_one_cycle",   0,   0,   0,   0,   1,  1,   1,   1,   0,  0,    0,  32'h80000003,  0,  1);

        quietInputs();
        rst_n = 1'b0;
        repeat (2) @(posedge hb_clk);
        #1 checkOutput("in_reset", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge hb_clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge hb_clk);
            applyStimulus(vecs[i]);
            @(posedge hb_clk);
            #1 checkOutput(vecs[i].name, vecs[i].exp_req, vecs[i].exp_cause,
                           vecs[i].exp_taken, vecs[i].exp_inh);
        end

        // Mid-HANDLER: reset must clear outputs without a clock edge.
        @(negedge hb_clk);
        quietInputs();
        @(posedge hb_clk);
        #1 checkOutput("pre_rst_handler", 1'b0, 32'h80000003, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst_handler", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge hb_clk);
        rst_n = 1'b1;
        repeat (2) @(posedge hb_clk);
        #1 checkOutput("idle_after_rst1", 1'b0, 32'h0, 1'b0, 1'b0);

        // Mid-REQ: pending request is discarded and not re-raised with sources low.
        @(negedge hb_clk);
        bus.mtimer_int = 1'b1;
        @(posedge hb_clk);
        #1 checkOutput("pre_rst_req", 1'b1, 32'h80000007, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_rst_req", 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge hb_clk);
        bus.mtimer_int = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(posedge hb_clk);
        #1 checkOutput("idle_after_rst2", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
